// File: rtl/ddr3_burst_reader.sv
// ----------------------------------------------------------------------------
// ddr3_burst_reader
//
// Read-side companion of the DDR3 burst write exerciser. It repeatedly issues
// one fixed-length read burst from a fixed address and checks every returned
// beat against the pattern the writer stores (byte 0 = beat index, the rest
// of the low word zero). Only the bits selected by CHECK_MASK are compared,
// because the writer only enables the low four byte lanes.
//
// Ports (all in the clk_ddr3 domain):
//   clk_ddr3         in   DDR3 user clock
//   reset_n          in   asynchronous active-low reset (released synchronously)
//   enable           in   1 = keep issuing bursts, 0 = finish burst then idle
//   wait_cnt_max     in   idle cycles inserted between bursts
//   stop_req         in   one-cycle pulse asking for a safe stop (latched)
//   ddram_busy       in   controller back-pressure on the read request
//   ddram_burstcnt   out  burst length (constant BURSTCNT)
//   ddram_addr       out  burst word address (constant ADDRESS)
//   ddram_rd         out  read request, held until accepted
//   ddram_dout       in   read data beat
//   ddram_dout_ready in   read data valid
//   stopped          out  reader is parked in STOP
//   err_flag         out  sticky, any beat mismatched
//   timeout_flag     out  sticky, a burst stalled for TIMEOUT cycles
//   stray_flag       out  sticky, read data seen while no burst was pending
//   err_count        out  mismatching beats, saturating
//   burst_count      out  completed bursts, saturating
//   first_err_beat   out  beat index of the first mismatch
//   first_err_data   out  low 32 bits of the first mismatching beat
// ----------------------------------------------------------------------------
module ddr3_burst_reader #(
  parameter logic [7:0]  BURSTCNT   = 8'h80,
  parameter logic [28:0] ADDRESS    = 29'h2400000,
  parameter logic [15:0] TIMEOUT    = 16'd4096,
  parameter logic [63:0] CHECK_MASK = 64'h00000000FFFFFFFF
) (
  input  logic        clk_ddr3,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [9:0]  wait_cnt_max,
  input  logic        stop_req,
  input  logic        ddram_busy,
  output logic [7:0]  ddram_burstcnt,
  output logic [28:0] ddram_addr,
  output logic        ddram_rd,
  input  logic [63:0] ddram_dout,
  input  logic        ddram_dout_ready,
  output logic        stopped,
  output logic        err_flag,
  output logic        timeout_flag,
  output logic        stray_flag,
  output logic [15:0] err_count,
  output logic [15:0] burst_count,
  output logic [7:0]  first_err_beat,
  output logic [31:0] first_err_data
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_REQ,
    ST_RECV,
    ST_STOP
  } state_t;

  localparam logic [7:0]  LAST_BEAT = BURSTCNT - 8'd1;
  localparam logic [15:0] TMO_LAST  = TIMEOUT - 16'd1;

  // Reset synchronizer: assertion reaches the core immediately, release is
  // delayed by three clk_ddr3 edges so the core leaves reset cleanly.
  logic [2:0] rst_sync_q;
  logic [2:0] rst_sync_d;
  logic       rst_n;

  always_comb begin
    rst_sync_d = {rst_sync_q[1:0], 1'b1};
  end

  always_ff @(posedge clk_ddr3 or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_q <= 3'b000;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  assign rst_n = rst_sync_q[2];

  // Core state.
  state_t      state_q,          state_d;
  logic [9:0]  wait_cnt_q,       wait_cnt_d;
  logic [7:0]  beat_idx_q,       beat_idx_d;
  logic [15:0] tmo_cnt_q,        tmo_cnt_d;
  logic        stop_lat_q,       stop_lat_d;
  logic        err_flag_q,       err_flag_d;
  logic        timeout_flag_q,   timeout_flag_d;
  logic        stray_flag_q,     stray_flag_d;
  logic [15:0] err_count_q,      err_count_d;
  logic [15:0] burst_count_q,    burst_count_d;
  logic [7:0]  first_err_beat_q, first_err_beat_d;
  logic [31:0] first_err_data_q, first_err_data_d;

  logic [63:0] expected_word;
  logic        beat_ok;

  // Expected beat pattern, compared only on the lanes the writer touched.
  always_comb begin
    expected_word = {56'b0, beat_idx_q};
    beat_ok       = ((ddram_dout ^ expected_word) & CHECK_MASK) == 64'd0;
  end

  // Next-state and bookkeeping logic for the burst sequencer.
  always_comb begin
    state_d          = state_q;
    wait_cnt_d       = wait_cnt_q;
    beat_idx_d       = beat_idx_q;
    tmo_cnt_d        = tmo_cnt_q;
    stop_lat_d       = stop_lat_q | stop_req;
    err_flag_d       = err_flag_q;
    timeout_flag_d   = timeout_flag_q;
    stray_flag_d     = stray_flag_q;
    err_count_d      = err_count_q;
    burst_count_d    = burst_count_q;
    first_err_beat_d = first_err_beat_q;
    first_err_data_d = first_err_data_q;

    // Data outside a pending burst is only flagged, never compared.
    if (ddram_dout_ready && (state_q != ST_RECV)) begin
      stray_flag_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (stop_lat_q) begin
          state_d = ST_STOP;
        end else if (enable) begin
          state_d    = ST_WAIT;
          wait_cnt_d = 10'd0;
        end
      end

      ST_WAIT: begin
        if (wait_cnt_q == wait_cnt_max) begin
          state_d = ST_REQ;
        end else begin
          wait_cnt_d = wait_cnt_q + 10'd1;
        end
      end

      // The request is held, whatever stop_req does, until the controller
      // takes it; dropping it under busy would violate the port protocol.
      ST_REQ: begin
        if (!ddram_busy) begin
          state_d    = ST_RECV;
          beat_idx_d = 8'd0;
          tmo_cnt_d  = 16'd0;
        end
      end

      ST_RECV: begin
        if (ddram_dout_ready) begin
          tmo_cnt_d  = 16'd0;
          beat_idx_d = beat_idx_q + 8'd1;
          if (!beat_ok) begin
            err_flag_d = 1'b1;
            if (err_count_q != 16'hFFFF) begin
              err_count_d = err_count_q + 16'd1;
            end
            // err_flag_q still clear means this is the first mismatch.
            if (!err_flag_q) begin
              first_err_beat_d = beat_idx_q;
              first_err_data_d = ddram_dout[31:0];
            end
          end
          if (beat_idx_q == LAST_BEAT) begin
            if (burst_count_q != 16'hFFFF) begin
              burst_count_d = burst_count_q + 16'd1;
            end
            if (stop_lat_q) begin
              state_d = ST_STOP;
            end else if (enable) begin
              state_d    = ST_WAIT;
              wait_cnt_d = 10'd0;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end else if (tmo_cnt_q == TMO_LAST) begin
          timeout_flag_d = 1'b1;
          state_d        = ST_STOP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
      end

      ST_STOP: begin
        state_d = ST_STOP;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // All core registers share the synchronized reset so a mid-burst reset
  // drops the request and clears every flag and counter at once.
  always_ff @(posedge clk_ddr3 or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      wait_cnt_q       <= 10'd0;
      beat_idx_q       <= 8'd0;
      tmo_cnt_q        <= 16'd0;
      stop_lat_q       <= 1'b0;
      err_flag_q       <= 1'b0;
      timeout_flag_q   <= 1'b0;
      stray_flag_q     <= 1'b0;
      err_count_q      <= 16'd0;
      burst_count_q    <= 16'd0;
      first_err_beat_q <= 8'd0;
      first_err_data_q <= 32'd0;
    end else begin
      state_q          <= state_d;
      wait_cnt_q       <= wait_cnt_d;
      beat_idx_q       <= beat_idx_d;
      tmo_cnt_q        <= tmo_cnt_d;
      stop_lat_q       <= stop_lat_d;
      err_flag_q       <= err_flag_d;
      timeout_flag_q   <= timeout_flag_d;
      stray_flag_q     <= stray_flag_d;
      err_count_q      <= err_count_d;
      burst_count_q    <= burst_count_d;
      first_err_beat_q <= first_err_beat_d;
      first_err_data_q <= first_err_data_d;
    end
  end

  // The request is decoded straight from the state register so it falls
  // in the same instant the asynchronous reset reaches the core.
  assign ddram_rd       = (state_q == ST_REQ);
  assign stopped        = (state_q == ST_STOP);
  assign ddram_burstcnt = BURSTCNT;
  assign ddram_addr     = ADDRESS;
  assign err_flag       = err_flag_q;
  assign timeout_flag   = timeout_flag_q;
  assign stray_flag     = stray_flag_q;
  assign err_count      = err_count_q;
  assign burst_count    = burst_count_q;
  assign first_err_beat = first_err_beat_q;
  assign first_err_data = first_err_data_q;

endmodule

// File: tb/tb_ddr3_burst_reader.sv
// ----------------------------------------------------------------------------
// tb_ddr3_burst_reader
//
// Directed bench for ddr3_burst_reader. A small read-port model answers each
// request with the writer's pattern, optionally with back-pressure, corrupted
// beats, a stop request or a truncated burst. Expected values are constants
// worked out by hand for the default parameters.
// ----------------------------------------------------------------------------
module tb_ddr3_burst_reader;

  logic        clk_ddr3 = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [9:0]  wait_cnt_max = 10'd4;
  logic        stop_req = 1'b0;
  logic        ddram_busy = 1'b0;
  logic [7:0]  ddram_burstcnt;
  logic [28:0] ddram_addr;
  logic        ddram_rd;
  logic [63:0] ddram_dout = 64'd0;
  logic        ddram_dout_ready = 1'b0;
  logic        stopped;
  logic        err_flag;
  logic        timeout_flag;
  logic        stray_flag;
  logic [15:0] err_count;
  logic [15:0] burst_count;
  logic [7:0]  first_err_beat;
  logic [31:0] first_err_data;

  int errors = 0;
  int checks = 0;
  int rd_cycles = 0;

  ddr3_burst_reader dut (
    .clk_ddr3         (clk_ddr3),
    .reset_n          (reset_n),
    .enable           (enable),
    .wait_cnt_max     (wait_cnt_max),
    .stop_req         (stop_req),
    .ddram_busy       (ddram_busy),
    .ddram_burstcnt   (ddram_burstcnt),
    .ddram_addr       (ddram_addr),
    .ddram_rd         (ddram_rd),
    .ddram_dout       (ddram_dout),
    .ddram_dout_ready (ddram_dout_ready),
    .stopped          (stopped),
    .err_flag         (err_flag),
    .timeout_flag     (timeout_flag),
    .stray_flag       (stray_flag),
    .err_count        (err_count),
    .burst_count      (burst_count),
    .first_err_beat   (first_err_beat),
    .first_err_data   (first_err_data)
  );

  // 100 MHz user clock.
  always #5 clk_ddr3 = ~clk_ddr3;

  // Count request cycles, sampled on the falling edge away from state changes.
  always @(negedge clk_ddr3) begin
    if (ddram_rd === 1'b1) rd_cycles++;
  end

  // One comparison: bumps the check count and reports any difference.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Hold reset for a few cycles, then wait out the release synchronizer.
  task automatic applyReset();
    @(negedge clk_ddr3);
    reset_n          = 1'b0;
    enable           = 1'b0;
    stop_req         = 1'b0;
    ddram_busy       = 1'b0;
    ddram_dout_ready = 1'b0;
    ddram_dout       = 64'd0;
    repeat (3) @(negedge clk_ddr3);
    reset_n = 1'b1;
    repeat (5) @(negedge clk_ddr3);
  endtask

  // Read-port model for one burst.
  //   n_beats     : beats returned (128 = full burst)
  //   busy_cycles : cycles busy is held after the request appears
  //   mode        : 0 clean, 1 corrupt beats 5/6, 2 stop at 40 + corrupt 100
  task automatic applyStimulus(input int n_beats, input int busy_cycles,
                               input int mode);
    logic [7:0] idx;
    @(negedge clk_ddr3);
    for (int i = 0; i < 300 && ddram_rd !== 1'b1; i++) @(negedge clk_ddr3);
    checkOutput("rd_rise", 64'(ddram_rd), 64'd1);
    if (busy_cycles > 0) begin
      ddram_busy = 1'b1;
      for (int i = 0; i < busy_cycles; i++) begin
        @(negedge clk_ddr3);
        checkOutput("rd_held_busy", 64'(ddram_rd), 64'd1);
        checkOutput("addr_busy", 64'(ddram_addr), 64'h2400000);
        checkOutput("burstcnt_busy", 64'(ddram_burstcnt), 64'h80);
      end
      ddram_busy = 1'b0;
    end
    @(negedge clk_ddr3);
    checkOutput("rd_drop_after_accept", 64'(ddram_rd), 64'd0);
    for (int b = 0; b < n_beats; b++) begin
      @(negedge clk_ddr3);
      idx              = b[7:0];
      ddram_dout_ready = 1'b1;
      ddram_dout       = {56'b0, idx};
      stop_req         = 1'b0;
      if (mode == 1 && b == 5) ddram_dout = 64'h00000000000000FF;
      if (mode == 1 && b == 6) ddram_dout = 64'hFFFF0000_00000006;
      if (mode == 2 && b == 40) stop_req = 1'b1;
      if (mode == 2 && b == 100) ddram_dout = 64'd0;
    end
    @(negedge clk_ddr3);
    ddram_dout_ready = 1'b0;
    ddram_dout       = 64'd0;
    stop_req         = 1'b0;
  endtask

  initial begin
    $display("[TB] ddr3_burst_reader directed test start");

    // Reset values while reset is held.
    repeat (3) @(negedge clk_ddr3);
    checkOutput("reset_rd", 64'(ddram_rd), 64'd0);
    checkOutput("reset_stopped", 64'(stopped), 64'd0);
    checkOutput("reset_err_flag", 64'(err_flag), 64'd0);
    checkOutput("reset_burst_count", 64'(burst_count), 64'd0);
    checkOutput("reset_burstcnt", 64'(ddram_burstcnt), 64'h80);
    checkOutput("reset_addr", 64'(ddram_addr), 64'h2400000);
    reset_n = 1'b1;
    repeat (5) @(negedge clk_ddr3);
    checkOutput("idle_rd", 64'(ddram_rd), 64'd0);

    // Three clean bursts with wait_cnt_max = 4.
    enable       = 1'b1;
    wait_cnt_max = 10'd4;
    applyStimulus(128, 0, 0);
    applyStimulus(128, 0, 0);
    applyStimulus(128, 0, 0);
    checkOutput("clean_burst_count", 64'(burst_count), 64'd3);
    checkOutput("clean_err_count", 64'(err_count), 64'd0);
    checkOutput("clean_err_flag", 64'(err_flag), 64'd0);
    checkOutput("clean_stray_flag", 64'(stray_flag), 64'd0);
    checkOutput("clean_rd_cycles", 64'(rd_cycles), 64'd3);

    // Back-pressure for 10 cycles: request stays up, then accepted.
    applyStimulus(128, 10, 0);
    checkOutput("busy_burst_count", 64'(burst_count), 64'd4);
    checkOutput("busy_rd_cycles", 64'(rd_cycles), 64'd14);

    // Corrupted beat 5; beat 6 differs only in masked upper bits.
    applyStimulus(128, 0, 1);
    checkOutput("corrupt_err_count", 64'(err_count), 64'd1);
    checkOutput("corrupt_err_flag", 64'(err_flag), 64'd1);
    checkOutput("corrupt_first_beat", 64'(first_err_beat), 64'd5);
    checkOutput("corrupt_first_data", 64'(first_err_data), 64'hFF);
    checkOutput("corrupt_burst_count", 64'(burst_count), 64'd5);

    // Stop request mid-burst; later beats are still checked.
    applyStimulus(128, 0, 2);
    checkOutput("stop_burst_count", 64'(burst_count), 64'd6);
    checkOutput("stop_err_count", 64'(err_count), 64'd2);
    checkOutput("stop_first_beat_kept", 64'(first_err_beat), 64'd5);
    checkOutput("stop_first_data_kept", 64'(first_err_data), 64'hFF);
    checkOutput("stop_stopped", 64'(stopped), 64'd1);
    repeat (50) @(negedge clk_ddr3);
    checkOutput("stop_still_stopped", 64'(stopped), 64'd1);
    checkOutput("stop_no_more_rd", 64'(rd_cycles), 64'd16);

    // Truncated burst: 64 beats only, then a timeout.
    applyReset();
    checkOutput("rst2_burst_count", 64'(burst_count), 64'd0);
    checkOutput("rst2_err_count", 64'(err_count), 64'd0);
    checkOutput("rst2_stopped", 64'(stopped), 64'd0);
    checkOutput("rst2_first_data", 64'(first_err_data), 64'd0);
    enable = 1'b1;
    applyStimulus(64, 0, 0);
    repeat (4000) @(negedge clk_ddr3);
    checkOutput("tmo_not_yet", 64'(timeout_flag), 64'd0);
    checkOutput("tmo_not_stopped_yet", 64'(stopped), 64'd0);
    repeat (200) @(negedge clk_ddr3);
    checkOutput("tmo_flag", 64'(timeout_flag), 64'd1);
    checkOutput("tmo_stopped", 64'(stopped), 64'd1);
    checkOutput("tmo_burst_count", 64'(burst_count), 64'd0);
    checkOutput("tmo_err_flag", 64'(err_flag), 64'd0);
    checkOutput("tmo_stray_before", 64'(stray_flag), 64'd0);
    ddram_dout_ready = 1'b1;
    ddram_dout       = 64'h0000000000000040;
    @(negedge clk_ddr3);
    ddram_dout_ready = 1'b0;
    @(negedge clk_ddr3);
    checkOutput("late_beat_stray", 64'(stray_flag), 64'd1);
    checkOutput("late_beat_err_count", 64'(err_count), 64'd0);

    // Asynchronous reset while a request is held under busy.
    applyReset();
    enable = 1'b1;
    @(negedge clk_ddr3);
    for (int i = 0; i < 300 && ddram_rd !== 1'b1; i++) @(negedge clk_ddr3);
    checkOutput("areset_rd_before", 64'(ddram_rd), 64'd1);
    ddram_busy = 1'b1;
    repeat (3) @(negedge clk_ddr3);
    checkOutput("areset_rd_held", 64'(ddram_rd), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("areset_rd", 64'(ddram_rd), 64'd0);
    checkOutput("areset_stopped", 64'(stopped), 64'd0);
    checkOutput("areset_err_flag", 64'(err_flag), 64'd0);
    checkOutput("areset_timeout_flag", 64'(timeout_flag), 64'd0);
    checkOutput("areset_stray_flag", 64'(stray_flag), 64'd0);
    checkOutput("areset_err_count", 64'(err_count), 64'd0);
    checkOutput("areset_burst_count", 64'(burst_count), 64'd0);
    checkOutput("areset_first_beat", 64'(first_err_beat), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ddr3_burst_reader.md
Name: ddr3_burst_reader

Overview:
- Read-side counterpart of the DDR3 burst write exerciser.
- Issues fixed-length read bursts on the DDRAM Avalon-style port: DDRAM_RD, DDRAM_BUSY, DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_DOUT, DDRAM_DOUT_READY.
- Checks every returned beat against the pattern the writer stores: byte0 = beat index, bytes1-3 = 0. Only the low 32 bits are checked, because the writer uses BE = 0x0F.
- Exposes pass/fail status and counters to the video/OSD layer, all in the clk_ddr3 domain.

Parameters:
- BURSTCNT, 8'h80, beats per read burst (1..255).
- ADDRESS, 29'h2400000, 64-bit word address of every burst.
- TIMEOUT, 16'd4096, maximum clk_ddr3 cycles between beats while in RECV.
- CHECK_MASK, 64'h00000000FFFFFFFF, bits of DDRAM_DOUT that are compared.

Ports:
- clk_ddr3  in  1  DDR3 user clock; also drives DDRAM_CLK.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  level; 1 = run bursts, 0 = finish the current burst then idle.
- wait_cnt_max  in  10  idle cycles between bursts.
- stop_req  in  1  single-cycle pulse requesting a safe stop; latched.
- ddram_busy  in  1  controller back-pressure.
- ddram_burstcnt  out  8  burst length.
- ddram_addr  out  29  burst address.
- ddram_rd  out  1  read request.
- ddram_dout  in  64  read data.
- ddram_dout_ready  in  1  read data valid.
- stopped  out  1  in STOP state.
- err_flag  out  1  sticky; any mismatch seen.
- timeout_flag  out  1  sticky; beat timeout occurred.
- stray_flag  out  1  sticky; dout_ready seen outside RECV.
- err_count  out  16  mismatching beats, saturating.
- burst_count  out  16  completed bursts, saturating.
- first_err_beat  out  8  beat index of the first mismatch.
- first_err_data  out  32  low 32 bits of the first mismatching word.

Behaviour:
- Reset (async assert, sync release via 3-flop synchronizer on clk_ddr3):
  - state = IDLE.
  - All outputs 0, except ddram_burstcnt = BURSTCNT and ddram_addr = ADDRESS, which are constant.
  - Counters 0; stop latch 0.
- stop_req latch: set on stop_req = 1; cleared only by reset.
- IDLE:
  - If stop latch set -> STOP.
  - Else if enable -> WAIT with wait counter = 0.
- WAIT:
  - Increment the wait counter each cycle.
  - When counter == wait_cnt_max -> REQ. With wait_cnt_max = 0, REQ is entered on the next cycle.
- REQ:
  - ddram_rd = 1; address and burst count held stable.
  - Request is accepted on the first cycle with ddram_rd = 1 and ddram_busy = 0.
  - Next state on acceptance: RECV, with beat index = 0 and timeout counter = 0. ddram_rd is 0 from the next cycle.
  - Never drop ddram_rd while busy.
  - stop_req arriving during REQ does not abort the request.
- RECV:
  - On each ddram_dout_ready:
    - Compare (dout & CHECK_MASK) against {56'b0, beat_idx} masked the same way.
    - On mismatch: increment err_count (saturate at FFFF) and set err_flag. If this is the first error since reset, capture first_err_beat and first_err_data.
    - Increment beat_idx and clear the timeout counter.
  - A beat arriving in the same cycle the request is accepted is not possible; one arriving on the cycle after is valid.
  - Timeout: counter reaches TIMEOUT with no beat -> set timeout_flag -> STOP.
  - After beat BURSTCNT-1 is accepted: burst_count++ (saturating). Then:
    - stop latch set -> STOP;
    - else enable = 1 -> WAIT;
    - else -> IDLE.
- STOP:
  - ddram_rd = 0, stopped = 1; remain in STOP until reset.
  - Late beats in STOP set stray_flag only.
- ddram_dout_ready in IDLE, WAIT or REQ: set stray_flag, no compare, counters unchanged.
- beat_idx is 8 bits; BURSTCNT = 255 gives indices 0..254, so there is no wrap.
- Mid-operation reset: immediate return to reset values; no request is left asserted.

Test Plan:
- Model returns 128 beats, each {56'b0, i}, 2 cycles after accept; wait_cnt_max = 4; run 3 bursts -> burst_count = 3, err_count = 0, err_flag = 0, ddram_rd high exactly 1 cycle per burst.
- Hold ddram_busy = 1 for 10 cycles after ddram_rd rises -> ddram_rd stays 1 with addr = 29'h2400000 and burstcnt = 8'h80 unchanged; accept occurs on the first busy = 0 cycle.
- Corrupt beat 5 to 64'h00000000000000FF and set upper bits 64'hFFFF0000_00000006 on beat 6 -> err_count = 1, first_err_beat = 5, first_err_data = 32'hFF; beat 6 passes because it is masked.
- Pulse stop_req at beat 40 -> the remaining beats are still checked, burst_count increments, then stopped = 1 and no further ddram_rd.
- Model stops after beat 63 -> after TIMEOUT cycles timeout_flag = 1 and stopped = 1; beats arriving afterwards set stray_flag.
- Assert reset_n = 0 while in REQ with busy = 1 -> ddram_rd = 0 asynchronously; all flags and counters are 0.
